usr_shift_reg: RTL and testbench

Parametrised universal shift register: next generation of the team's 4-bit PIPO register. It adds per-operation modes (parallel load, logical shift left/right, rotate left/right), multi-bit shift counts executed one bit per clock, serial inputs and outputs at both ends, and a busy/done handshake. It sits between a controller that issues single-cycle `start` commands and datapath logic that consumes `parallel_out` or the serial ends.

---
 rtl/usr_shift_reg.sv | 129 ++++++++++++
 tb/tb_usr_shift_reg.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/usr_shift_reg.sv
// Universal shift register: parallel load, logical shift and rotate in both
// directions, multi-step counts executed one bit per clock with a busy/done handshake.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start; load and single-step commands finish here
// SHIFT | executing the remaining steps of a latched shift/rotate command
module usr_shift_reg #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CW-1:0]    count,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             serial_in_left,
    input  logic             serial_in_right,
    output logic [WIDTH-1:0] parallel_out,
    output logic             serial_out_left,
    output logic             serial_out_right,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;

    localparam logic [CW-1:0] MAX_STEPS = CW'(WIDTH);

    state_t        state;
    logic [2:0]    op_mode;
    logic [CW-1:0] remaining;
    logic [CW-1:0] n_steps;

    // Serial inputs feed each step as it happens; they are never latched.
    function automatic logic [WIDTH-1:0] step_fn(
        input logic [WIDTH-1:0] r,
        input logic [2:0]       m,
        input logic             sin_left,
        input logic             sin_right
    );
        logic [WIDTH-1:0] res;
        res = r;
        case (m)
            MODE_SHL: res = {r[WIDTH-2:0], sin_right};
            MODE_SHR: res = {sin_left, r[WIDTH-1:1]};
            MODE_ROL: res = {r[WIDTH-2:0], r[WIDTH-1]};
            MODE_ROR: res = {r[0], r[WIDTH-1:1]};
            default:  res = r;
        endcase
        return res;
    endfunction

    always_comb begin
        n_steps = count;
        if (count > MAX_STEPS) begin
            n_steps = MAX_STEPS;
        end
    end

    assign serial_out_left  = parallel_out[WIDTH-1];
    assign serial_out_right = parallel_out[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            op_mode      <= MODE_HOLD;
            remaining    <= '0;
            parallel_out <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (mode)
                            MODE_LOAD: begin
                                parallel_out <= parallel_in;
                                done         <= 1'b1;
                            end
                            MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR: begin
                                op_mode <= mode;
                                if (n_steps == '0) begin
                                    done <= 1'b1;
                                end else begin
                                    // First step executes on the start edge itself.
                                    parallel_out <= step_fn(parallel_out, mode,
                                                            serial_in_left, serial_in_right);
                                    remaining <= n_steps - CW'(1);
                                    if (n_steps == CW'(1)) begin
                                        done <= 1'b1;
                                    end else begin
                                        busy  <= 1'b1;
                                        state <= SHIFT;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                SHIFT: begin
                    parallel_out <= step_fn(parallel_out, op_mode,
                                            serial_in_left, serial_in_right);
                    remaining <= remaining - CW'(1);
                    if (remaining == CW'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usr_shift_reg.sv
// Directed self-checking bench for usr_shift_reg (WIDTH=4) with hand-computed vectors.
module tb_usr_shift_reg;

    localparam int WIDTH = 4;
    localparam int CW    = $clog2(WIDTH + 1);

    logic             clk;
    logic             reset;
    logic             start;
    logic [2:0]       mode;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] parallel_in;
    logic             serial_in_left;
    logic             serial_in_right;
    logic [WIDTH-1:0] parallel_out;
    logic             serial_out_left;
    logic             serial_out_right;
    logic             busy;
    logic             done;

    int n_cmp = 0;
    int n_err = 0;

    usr_shift_reg #(.WIDTH(WIDTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .mode             (mode),
        .count            (count),
        .parallel_in      (parallel_in),
        .serial_in_left   (serial_in_left),
        .serial_in_right  (serial_in_right),
        .parallel_out     (parallel_out),
        .serial_out_left  (serial_out_left),
        .serial_out_right (serial_out_right),
        .busy             (busy),
        .done             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [3:0] po, input logic b, input logic d);
        chk({tag, ".po"}, 32'(parallel_out), 32'(po));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".done"}, 32'(done), 32'(d));
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        mode = 3'b001;
        count = '0;
        parallel_in = 4'b1110;
        serial_in_left = 1'b0;
        serial_in_right = 1'b0;

        // Reset holds everything clear even with a load pending.
        tick();
        tick();
        chk_state("reset", 4'b0000, 1'b0, 1'b0);
        chk("reset.sol", 32'(serial_out_left), 32'd0);
        chk("reset.sor", 32'(serial_out_right), 32'd0);
        start = 1'b0;
        reset = 1'b0;
        tick();
        chk_state("post_reset", 4'b0000, 1'b0, 1'b0);

        // Load.
        mode = 3'b001; parallel_in = 4'b1010; start = 1'b1;
        tick();
        start = 1'b0;
        chk_state("load", 4'b1010, 1'b0, 1'b1);
        chk("load.sol", 32'(serial_out_left), 32'd1);
        chk("load.sor", 32'(serial_out_right), 32'd0);
        tick();
        chk_state("load_after", 4'b1010, 1'b0, 1'b0);

        // Shift left by 2 with serial_in_right=1.
        mode = 3'b010; count = 3'd2; serial_in_right = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk_state("shl_1", 4'b0101, 1'b1, 1'b0);
        tick();
        chk_state("shl_2", 4'b1011, 1'b0, 1'b1);
        tick();
        chk_state("shl_idle", 4'b1011, 1'b0, 1'b0);

        // Rotate right with count 7, clamped to 4.
        mode = 3'b101; count = 3'd7; start = 1'b1;
        tick();
        start = 1'b0;
        chk_state("ror_1", 4'b1101, 1'b1, 1'b0);
        tick();
        chk_state("ror_2", 4'b1110, 1'b1, 1'b0);
        tick();
        chk_state("ror_3", 4'b0111, 1'b1, 1'b0);
        tick();
        chk_state("ror_4", 4'b1011, 1'b0, 1'b1);
        tick();
        chk_state("ror_idle", 4'b1011, 1'b0, 1'b0);

        // Ignored start while busy, then asynchronous abort.
        mode = 3'b001; parallel_in = 4'b1100; start = 1'b1;
        tick();
        start = 1'b0;
        chk_state("load_1100", 4'b1100, 1'b0, 1'b1);
        mode = 3'b011; count = 3'd4; serial_in_left = 1'b0; start = 1'b1;
        tick();
        chk_state("shr_1", 4'b0110, 1'b1, 1'b0);
        mode = 3'b001; parallel_in = 4'b1111; start = 1'b1;
        tick();
        start = 1'b0;
        chk_state("shr_2_ignore", 4'b0011, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk_state("abort_async", 4'b0000, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        chk_state("abort_no_done1", 4'b0000, 1'b0, 1'b0);
        tick();
        chk_state("abort_no_done2", 4'b0000, 1'b0, 1'b0);

        // Reserved mode, count=0, back-to-back single step.
        mode = 3'b001; parallel_in = 4'b1100; start = 1'b1;
        tick();
        chk_state("reload_1100", 4'b1100, 1'b0, 1'b1);
        mode = 3'b110;
        tick();
        start = 1'b0;
        chk_state("reserved", 4'b1100, 1'b0, 1'b0);
        mode = 3'b011; count = 3'd0; start = 1'b1;
        tick();
        chk_state("cnt0", 4'b1100, 1'b0, 1'b1);
        count = 3'd1; serial_in_left = 1'b1;
        tick();
        start = 1'b0;
        chk_state("cnt1_b2b", 4'b1110, 1'b0, 1'b1);
        tick();
        chk_state("cnt1_idle", 4'b1110, 1'b0, 1'b0);

        // Rotate left by full width restores the value.
        mode = 3'b100; count = 3'd4; start = 1'b1;
        tick();
        start = 1'b0;
        chk_state("rol_1", 4'b1101, 1'b1, 1'b0);
        tick();
        tick();
        chk_state("rol_3", 4'b0111, 1'b1, 1'b0);
        tick();
        chk_state("rol_4", 4'b1110, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
